// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage flush-to-zero IEEE-style adder/subtractor with RNE rounding and valid/ready flow control
// Ports: clk, rst (async, active-high); in_valid/in_ready + a, b, op (0 add, 1 subtract) on the input side;
// out_valid/out_ready + result, flag_invalid, flag_overflow, flag_inexact on the output side.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_invalid,
  output logic         flag_overflow,
  output logic         flag_inexact
);
  localparam int SW = MAN_W + 5;
  localparam int LW = $clog2(SW);
  localparam int XW = EXP_W + LW + 2;
  localparam int MAXS = MAN_W + 3;
  localparam int EMAX = 2**EXP_W - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LW-1:0] lzc(input logic [SW-2:0] x);
    lzc = LW'(SW - 1);
    for (int i = 0; i < SW - 1; i++)
      if (x[i]) lzc = LW'(SW - 2 - i);
  endfunction

  // whole pipe freezes while a result waits for the consumer
  assign in_ready = !(out_valid && !out_ready);

  logic sa, sb, a_nan, b_nan, a_inf, b_inf, swap, sl, ss, sp_nan;
  logic [W-2:0] ka, kb, kl, ks;
  logic [EXP_W-1:0] el, es, d;
  logic [31:0] dz;
  logic [LW-1:0] sh;
  logic [2*MAN_W+3:0] ext;
  logic [W-1:0] sp_res;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ op;
  assign a_nan = &a[W-2:MAN_W] && |a[MAN_W-1:0];
  assign b_nan = &b[W-2:MAN_W] && |b[MAN_W-1:0];
  assign a_inf = &a[W-2:MAN_W] && !(|a[MAN_W-1:0]);
  assign b_inf = &b[W-2:MAN_W] && !(|b[MAN_W-1:0]);
  // subnormals collapse to zero magnitude here, so the hidden bit is simply |exponent
  assign ka = |a[W-2:MAN_W] ? a[W-2:0] : '0;
  assign kb = |b[W-2:MAN_W] ? b[W-2:0] : '0;
  assign swap = kb > ka;
  assign kl = swap ? kb : ka;
  assign ks = swap ? ka : kb;
  assign sl = swap ? sb : sa;
  assign ss = swap ? sa : sb;
  assign el = kl[W-2:MAN_W];
  assign es = ks[W-2:MAN_W];
  assign d = el - es;
  assign dz = 32'(d);
  assign sh = dz > 32'(MAXS) ? LW'(MAXS) : LW'(dz);
  // low MAN_W+3 bits catch everything shifted past the round bit
  assign ext = {|es, ks[MAN_W-1:0], {(MAN_W+3){1'b0}}} >> sh;
  assign sp_nan = a_nan || b_nan || (a_inf && b_inf && (sa ^ sb));
  assign sp_res = sp_nan ? QNAN : a_inf ? {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  logic v1, s1_sign, s1_sub, s1_st, s1_sp, s1_nan;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W:0] s1_ml;
  logic [MAN_W+2:0] s1_al;
  logic [W-1:0] s1_spres;

  logic [SW-1:0] lhs, rhs, sum;
  // sticky rides as the LSB so a borrow through it still rounds correctly
  assign lhs = {1'b0, s1_ml, 3'b000};
  assign rhs = {1'b0, s1_al, s1_st};
  assign sum = s1_sub ? lhs - rhs : lhs + rhs;

  logic v2, s2_sign, s2_sub, s2_sp, s2_nan;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0] s2_sum;
  logic [LW-1:0] s2_lz;
  logic [W-1:0] s2_spres;

  logic c, g, rs, inc, zero, ovf, unf;
  logic [SW-2:0] nm;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] fr;
  logic signed [XW-1:0] en_x, en_f;
  logic [W-1:0] r_res;

  assign c = s2_sum[SW-1];
  assign nm = c ? {s2_sum[SW-1:2], |s2_sum[1:0]} : s2_sum[SW-2:0] << s2_lz;
  assign en_x = XW'(s2_exp) + XW'(c) - (c ? XW'(0) : XW'(s2_lz));
  assign g = nm[2];
  assign rs = |nm[1:0];
  assign inc = g && (rs || nm[3]);
  assign mr = {1'b0, nm[SW-2:3]} + (MAN_W+2)'(inc);
  assign en_f = en_x + XW'(mr[MAN_W+1]);
  assign fr = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
  assign zero = s2_sum == '0;
  assign ovf = en_f >= XW'(EMAX);
  assign unf = en_f <= XW'(0);
  // an exact zero is +0 unless both operands were zeros of the same sign
  assign r_res = s2_sp ? s2_spres :
                 zero ? {s2_sign && !s2_sub, {(W-1){1'b0}}} :
                 ovf ? {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                 unf ? {s2_sign, {(W-1){1'b0}}} :
                 {s2_sign, en_f[EXP_W-1:0], fr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      s1_sign <= 1'b0;
      s1_sub <= 1'b0;
      s1_st <= 1'b0;
      s1_sp <= 1'b0;
      s1_nan <= 1'b0;
      s1_exp <= '0;
      s1_ml <= '0;
      s1_al <= '0;
      s1_spres <= '0;
      v2 <= 1'b0;
      s2_sign <= 1'b0;
      s2_sub <= 1'b0;
      s2_sp <= 1'b0;
      s2_nan <= 1'b0;
      s2_exp <= '0;
      s2_sum <= '0;
      s2_lz <= '0;
      s2_spres <= '0;
      out_valid <= 1'b0;
      result <= '0;
      flag_invalid <= 1'b0;
      flag_overflow <= 1'b0;
      flag_inexact <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
      s1_sign <= sl;
      s1_sub <= sl ^ ss;
      s1_st <= |ext[MAN_W:0];
      s1_sp <= sp_nan || a_inf || b_inf;
      s1_nan <= sp_nan;
      s1_exp <= el;
      s1_ml <= {|el, kl[MAN_W-1:0]};
      s1_al <= ext[2*MAN_W+3:MAN_W+1];
      s1_spres <= sp_res;
      v2 <= v1;
      s2_sign <= s1_sign;
      s2_sub <= s1_sub;
      s2_sp <= s1_sp;
      s2_nan <= s1_nan;
      s2_exp <= s1_exp;
      s2_sum <= sum;
      s2_lz <= lzc(sum[SW-2:0]);
      s2_spres <= s1_spres;
      out_valid <= v2;
      result <= r_res;
      flag_invalid <= s2_sp && s2_nan;
      flag_overflow <= !s2_sp && !zero && ovf;
      flag_inexact <= !s2_sp && !zero && (ovf || unf || g || rs);
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed checks of fp_addsub_pipe in single and half precision
module tb_fp_addsub_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid, in_ready, op, out_valid, out_ready, flag_invalid, flag_overflow, flag_inexact;
  logic [31:0] a, b, result;
  logic h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready, h_inv, h_ovf, h_inx;
  logic [15:0] h_a, h_b, h_result;

  int checks = 0;
  int errors = 0;

  fp_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_invalid(flag_invalid), .flag_overflow(flag_overflow), .flag_inexact(flag_inexact)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b), .op(h_op),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
    .flag_invalid(h_inv), .flag_overflow(h_ovf), .flag_inexact(h_inx)
  );

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                       output logic [31:0] r, output logic [2:0] f, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb; op = top; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    r = result;
    f = {flag_invalid, flag_overflow, flag_inexact};
  endtask

  task automatic issue_h(input logic [15:0] ta, input logic [15:0] tb,
                         output logic [15:0] r, output logic [2:0] f, output int lat);
    @(negedge clk);
    h_in_valid = 1'b1; h_a = ta; h_b = tb; h_op = 1'b0;
    @(negedge clk);
    h_in_valid = 1'b0;
    lat = 1;
    while (!h_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    r = h_result;
    f = {h_inv, h_ovf, h_inx};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_op = 1'b0; h_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, result, flag_invalid, flag_overflow, flag_inexact} !== 36'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%h f=%b%b%b want all zero", out_valid, result,
               flag_invalid, flag_overflow, flag_inexact);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic;
    logic [31:0] r;
    logic [2:0] f;
    int lat;
    issue(32'h411C0000, 32'h3F100000, 1'b0, r, f, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL add_latency got %0d want 3", lat); end
    checks++;
    if (r !== 32'h41250000 || f !== 3'b000) begin errors++; $display("FAIL add got %h f=%b want 41250000 f=000", r, f); end
    issue(32'h411C0000, 32'h3F100000, 1'b1, r, f, lat);
    checks++;
    if (r !== 32'h41130000 || f !== 3'b000) begin errors++; $display("FAIL sub got %h f=%b want 41130000 f=000", r, f); end
    issue(32'h80000000, 32'h80000000, 1'b0, r, f, lat);
    checks++;
    if (r !== 32'h80000000 || f !== 3'b000) begin errors++; $display("FAIL negzero got %h f=%b want 80000000 f=000", r, f); end
    issue(32'hC0490FDB, 32'h00000000, 1'b0, r, f, lat);
    checks++;
    if (r !== 32'hC0490FDB || f !== 3'b000) begin errors++; $display("FAIL plus_zero got %h f=%b want c0490fdb f=000", r, f); end
  endtask

  task automatic test_rounding;
    logic [31:0] r;
    logic [2:0] f;
    int lat;
    issue(32'h3F800000, 32'h33800000, 1'b0, r, f, lat);
    checks++;
    if (r !== 32'h3F800000 || f !== 3'b001) begin errors++; $display("FAIL tie_even got %h f=%b want 3f800000 f=001", r, f); end
    issue(32'h3F800000, 32'h33800001, 1'b0, r, f, lat);
    checks++;
    if (r !== 32'h3F800001 || f !== 3'b001) begin errors++; $display("FAIL tie_up got %h f=%b want 3f800001 f=001", r, f); end
  endtask

  task automatic test_cancel_overflow;
    logic [31:0] r;
    logic [2:0] f;
    int lat;
    issue(32'h3F800000, 32'h3F800000, 1'b1, r, f, lat);
    checks++;
    if (r !== 32'h00000000 || f !== 3'b000) begin errors++; $display("FAIL cancel got %h f=%b want 00000000 f=000", r, f); end
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, f, lat);
    checks++;
    if (r !== 32'h7F800000 || f !== 3'b011) begin errors++; $display("FAIL overflow got %h f=%b want 7f800000 f=011", r, f); end
  endtask

  task automatic test_specials;
    logic [31:0] r;
    logic [2:0] f;
    int lat;
    issue(32'h7F800000, 32'h7F800000, 1'b1, r, f, lat);
    checks++;
    if (r !== 32'h7FC00000 || f !== 3'b100) begin errors++; $display("FAIL inf_minus_inf got %h f=%b want 7fc00000 f=100", r, f); end
    issue(32'h7FC00001, 32'h3F800000, 1'b0, r, f, lat);
    checks++;
    if (r !== 32'h7FC00000 || f !== 3'b100) begin errors++; $display("FAIL nan_in got %h f=%b want 7fc00000 f=100", r, f); end
    issue(32'hFF800000, 32'h3F800000, 1'b0, r, f, lat);
    checks++;
    if (r !== 32'hFF800000 || f !== 3'b000) begin errors++; $display("FAIL neg_inf got %h f=%b want ff800000 f=000", r, f); end
  endtask

  task automatic test_half;
    logic [15:0] r;
    logic [2:0] f;
    int lat;
    issue_h(16'h3C00, 16'h3C00, r, f, lat);
    checks++;
    if (lat !== 3 || r !== 16'h4000 || f !== 3'b000) begin
      errors++; $display("FAIL half_add got %h f=%b lat=%0d want 4000 f=000 lat=3", r, f, lat);
    end
    issue_h(16'h7BFF, 16'h7BFF, r, f, lat);
    checks++;
    if (r !== 16'h7C00 || f !== 3'b011) begin errors++; $display("FAIL half_overflow got %h f=%b want 7c00 f=011", r, f); end
  endtask

  task automatic test_back_to_back;
    int sent, got, stalls, cyc;
    logic [31:0] want;
    sent = 0; got = 0; stalls = 0; cyc = 0;
    while (got < 10 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 10);
      in_valid = sent < 10;
      a = 32'h3F800000 + (32'(sent) << 12);
      b = a;
      op = 1'b0;
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL stream_in_ready cyc=%0d got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (!in_ready) stalls++;
      if (out_valid && out_ready) begin
        want = 32'h40000000 + (32'(got) << 12);
        checks++;
        if (result !== want) begin errors++; $display("FAIL stream_result idx=%0d got %h want %h", got, result, want); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 10) begin errors++; $display("FAIL stream_count got %0d want 10", got); end
    checks++;
    if (stalls !== 4) begin errors++; $display("FAIL stream_stalls got %0d want 4", stalls); end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_extra got out_valid=%b want 0", out_valid); end
    end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale got out_valid=%b r=%h want 0", out_valid, result); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_rounding;
    test_cancel_overflow;
    test_specials;
    test_half;
    test_back_to_back;
    test_reset_midflight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
